// File: rtl/serial_cmd_parser_if.sv
// UART receive-side byte channel feeding serial_cmd_parser.
// The master drives bytes; the parser consumes them through the slave modport.
interface serial_cmd_parser_if;
  logic       iRx_ready;
  logic [7:0] iData;

  modport master (output iRx_ready, output iData);
  modport slave  (input  iRx_ready, input  iData);
endinterface

// File: rtl/serial_cmd_parser.sv
// Frames HDR0 HDR1 M[0..N-1] SIG KICK CRC_H CRC_L END from UART bytes and checks CRC-16/CCITT-FALSE.
// Optional macro WATCHDOG_STOP_EN zeroes motor and signal outputs after WDOG_CYC cycles without a valid frame.
module serial_cmd_parser #(
  parameter int unsigned NUM_MOTORS  = 3,
  parameter logic [7:0]  HDR0        = 8'hFF,
  parameter logic [7:0]  HDR1        = 8'hFA,
  parameter logic [7:0]  END_BYTE    = 8'h00,
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter int unsigned WDOG_CYC    = 5000000
) (
  input  logic                    iCLK,
  input  logic                    iRst_n,
  serial_cmd_parser_if.slave      rx_if,
  output logic [8*NUM_MOTORS-1:0] oCMD_Motor,
  output logic [7:0]              oSignal,
  output logic [7:0]              oKick,
  output logic                    oRx_done,
  output logic                    oCrcSuccess,
  output logic [15:0]             oCrc,
  output logic                    oFrameErr,
  output logic [15:0]             oPktCount
);
  localparam int unsigned PW = NUM_MOTORS + 2;
  localparam int unsigned IW = $clog2(PW);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CRCH    = 3'd3,
    S_CRCL    = 3'd4,
    S_END     = 3'd5
  } state_t;

  state_t        r_state;
  logic          r_rdy_q;
  logic [IW-1:0] r_idx;
  logic [15:0]   r_crc;
  logic [15:0]   r_rx_crc;
  logic [7:0]    r_shadow [PW];
  logic [TW-1:0] r_tmo_cnt;

  logic          w_accept;
  logic          w_frame_ok;
  logic [15:0]   w_crc_next;

`ifdef WATCHDOG_STOP_EN
  localparam int unsigned WW = $clog2(WDOG_CYC + 1);
  logic [WW-1:0] r_wdog_cnt;
`endif

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
    logic [15:0] c;
    c = crc_in ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  assign w_accept   = rx_if.iRx_ready & ~r_rdy_q;
  assign w_crc_next = crc16_byte(r_crc, rx_if.iData);
  assign w_frame_ok = w_accept && (r_state == S_END) && (rx_if.iData == END_BYTE) && (r_crc == r_rx_crc);

  // Frame FSM, inter-byte timeout and all registered outputs.
  always_ff @(posedge iCLK) begin
    if (!iRst_n) begin
      r_state     <= S_IDLE;
      r_rdy_q     <= 1'b0;
      r_idx       <= '0;
      r_crc       <= 16'hFFFF;
      r_rx_crc    <= 16'h0000;
      r_tmo_cnt   <= '0;
      for (int k = 0; k < PW; k++) r_shadow[k] <= 8'h00;
      oCMD_Motor  <= '0;
      oSignal     <= 8'h00;
      oKick       <= 8'h00;
      oRx_done    <= 1'b0;
      oCrcSuccess <= 1'b0;
      oCrc        <= 16'h0000;
      oFrameErr   <= 1'b0;
      oPktCount   <= 16'h0000;
`ifdef WATCHDOG_STOP_EN
      r_wdog_cnt  <= '0;
`endif
    end else begin
      r_rdy_q   <= rx_if.iRx_ready;
      oRx_done  <= 1'b0;
      oFrameErr <= 1'b0;
      if (w_accept) begin
        r_tmo_cnt <= '0;
        case (r_state)
          S_IDLE: begin
            if (rx_if.iData == HDR0) r_state <= S_HDR;
            else                     r_state <= S_IDLE;
          end
          // A repeated HDR0 keeps us here so FF FF FA still synchronises.
          S_HDR: begin
            if (rx_if.iData == HDR1) begin
              r_state <= S_PAYLOAD;
              r_idx   <= '0;
              r_crc   <= 16'hFFFF;
            end else if (rx_if.iData != HDR0) begin
              r_state <= S_IDLE;
            end else begin
              r_state <= S_HDR;
            end
          end
          S_PAYLOAD: begin
            r_shadow[r_idx] <= rx_if.iData;
            r_crc           <= w_crc_next;
            if (r_idx == IW'(PW - 1)) r_state <= S_CRCH;
            else                      r_idx   <= r_idx + IW'(1);
          end
          S_CRCH: begin
            r_rx_crc[15:8] <= rx_if.iData;
            r_state        <= S_CRCL;
          end
          S_CRCL: begin
            r_rx_crc[7:0] <= rx_if.iData;
            r_state       <= S_END;
          end
          S_END: begin
            r_state <= S_IDLE;
            if (rx_if.iData == END_BYTE) begin
              oRx_done    <= 1'b1;
              oCrc        <= r_crc;
              oCrcSuccess <= (r_crc == r_rx_crc);
              if (w_frame_ok) begin
                for (int k = 0; k < NUM_MOTORS; k++) oCMD_Motor[8*k +: 8] <= r_shadow[k];
                oSignal   <= r_shadow[NUM_MOTORS];
                oKick     <= r_shadow[NUM_MOTORS + 1];
                oPktCount <= oPktCount + 16'd1;
              end else begin
                oPktCount <= oPktCount;
              end
            end else begin
              oFrameErr <= 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end else if (r_state != S_IDLE) begin
        if (r_tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
          oFrameErr <= 1'b1;
          r_state   <= S_IDLE;
          r_tmo_cnt <= '0;
        end else begin
          r_tmo_cnt <= r_tmo_cnt + TW'(1);
        end
      end else begin
        r_tmo_cnt <= '0;
      end
`ifdef WATCHDOG_STOP_EN
      // Saturated watchdog keeps the motors parked until the next valid frame.
      if (w_frame_ok) begin
        r_wdog_cnt <= '0;
      end else if (r_wdog_cnt == WW'(WDOG_CYC)) begin
        oCMD_Motor <= '0;
        oSignal    <= 8'h00;
      end else begin
        r_wdog_cnt <= r_wdog_cnt + WW'(1);
      end
`endif
    end
  end
endmodule

// File: tb/tb_serial_cmd_parser.sv
// Self-checking bench for serial_cmd_parser: a byte-queue frame model checked every cycle,
// plus directed literal checks on a 3-motor and a 5-motor instance.
`timescale 1ns/1ps
module tb_serial_cmd_parser;
  localparam int NM_A = 3;
  localparam int NM_B = 5;
  localparam int TMO  = 300;
  localparam int WDG  = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_cmd_parser_if if_a();
  serial_cmd_parser_if if_b();

  logic [8*NM_A-1:0] a_motor;
  logic [7:0]        a_sig, a_kick;
  logic              a_done, a_succ, a_err;
  logic [15:0]       a_crc, a_pkt;
  logic [8*NM_B-1:0] b_motor;
  logic [7:0]        b_sig, b_kick;
  logic              b_done, b_succ, b_err;
  logic [15:0]       b_crc, b_pkt;

  serial_cmd_parser #(.NUM_MOTORS(NM_A), .TIMEOUT_CYC(TMO)) dut_a (
    .iCLK(clk), .iRst_n(rst_n), .rx_if(if_a),
    .oCMD_Motor(a_motor), .oSignal(a_sig), .oKick(a_kick), .oRx_done(a_done),
    .oCrcSuccess(a_succ), .oCrc(a_crc), .oFrameErr(a_err), .oPktCount(a_pkt));

  serial_cmd_parser #(.NUM_MOTORS(NM_B), .TIMEOUT_CYC(TMO), .WDOG_CYC(WDG)) dut_b (
    .iCLK(clk), .iRst_n(rst_n), .rx_if(if_b),
    .oCMD_Motor(b_motor), .oSignal(b_sig), .oKick(b_kick), .oRx_done(b_done),
    .oCrcSuccess(b_succ), .oCrc(b_crc), .oFrameErr(b_err), .oPktCount(b_pkt));

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Bit-serial CRC-16/CCITT-FALSE over a byte queue.
  function automatic logic [15:0] crc_model(input byte unsigned d[$]);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (d[i]) begin
      for (int bi = 7; bi >= 0; bi--) begin
        logic fb;
        fb = c[15] ^ d[i][bi];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction

  // Frame-level model of instance A, fed from the bench's own stimulus.
  logic [8*NM_A-1:0] m_motor;
  logic [7:0]        m_sig, m_kick;
  logic              m_succ, m_done, m_err;
  logic [15:0]       m_crc, m_pkt;
  int                m_stage, m_sil;
  bit                m_prev;
  bit                chk_en = 1'b0;
  byte unsigned      m_q[$];

  always @(posedge clk) begin
    bit           acc;
    byte unsigned b;
    byte unsigned pl[$];
    logic [15:0]  rx;
    m_done = 1'b0;
    m_err  = 1'b0;
    if (!rst_n) begin
      m_motor = '0; m_sig = 8'h00; m_kick = 8'h00; m_succ = 1'b0;
      m_crc = 16'h0000; m_pkt = 16'h0000;
      m_stage = 0; m_sil = 0; m_prev = 1'b0; m_q.delete();
      chk_en = 1'b1;
    end else begin
      acc    = if_a.iRx_ready && !m_prev;
      m_prev = if_a.iRx_ready;
      b      = if_a.iData;
      if (acc) begin
        m_sil = 0;
        case (m_stage)
          0: if (b == 8'hFF) m_stage = 1;
          1: begin
            if (b == 8'hFA) begin m_stage = 2; m_q.delete(); end
            else if (b != 8'hFF) m_stage = 0;
          end
          default: begin
            m_q.push_back(b);
            if (m_q.size() == NM_A + 5) begin
              if (m_q[NM_A+4] == 8'h00) begin
                pl     = m_q[0:NM_A+1];
                rx     = {m_q[NM_A+2], m_q[NM_A+3]};
                m_done = 1'b1;
                m_crc  = crc_model(pl);
                m_succ = (m_crc == rx);
                if (m_succ) begin
                  for (int k = 0; k < NM_A; k++) m_motor[8*k +: 8] = m_q[k];
                  m_sig  = m_q[NM_A];
                  m_kick = m_q[NM_A+1];
                  m_pkt  = m_pkt + 16'd1;
                end
              end else begin
                m_err = 1'b1;
              end
              m_stage = 0;
            end
          end
        endcase
      end else if (m_stage != 0) begin
        m_sil++;
        if (m_sil == TMO) begin m_err = 1'b1; m_stage = 0; end
      end
    end
  end

  // Per-cycle comparison of instance A against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("motor", 64'(a_motor), 64'(m_motor));
      check("signal", 64'(a_sig), 64'(m_sig));
      check("kick", 64'(a_kick), 64'(m_kick));
      check("rx_done", 64'(a_done), 64'(m_done));
      check("frame_err", 64'(a_err), 64'(m_err));
      check("crc_ok", 64'(a_succ), 64'(m_succ));
      check("crc", 64'(a_crc), 64'(m_crc));
      check("pkt_count", 64'(a_pkt), 64'(m_pkt));
      if (a_done) done_cnt++;
      if (a_err) err_cnt++;
    end
  end

  task automatic send_byte(input int sel, input logic [7:0] b);
    @(posedge clk); #1;
    if (sel == 0) begin if_a.iData = b; if_a.iRx_ready = 1'b1; end
    else          begin if_b.iData = b; if_b.iRx_ready = 1'b1; end
    repeat (3) @(posedge clk);
    #1;
    if (sel == 0) if_a.iRx_ready = 1'b0;
    else          if_b.iRx_ready = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic send_frame(input int sel, input byte unsigned pl[$], input logic [7:0] crc_l_xor,
                            input logic [7:0] end_b);
    logic [15:0] c;
    c = crc_model(pl);
    send_byte(sel, 8'hFF);
    send_byte(sel, 8'hFA);
    foreach (pl[i]) send_byte(sel, pl[i]);
    send_byte(sel, c[15:8]);
    send_byte(sel, c[7:0] ^ crc_l_xor);
    send_byte(sel, end_b);
  endtask

  initial begin
    byte unsigned p[$];
    int d0, e0;
    if_a.iRx_ready = 1'b0; if_a.iData = 8'h00;
    if_b.iRx_ready = 1'b0; if_b.iData = 8'h00;

    p = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    check("crc_model_check_string", 64'(crc_model(p)), 64'h29B1);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_motor", 64'(a_motor), 64'h0);
    check("reset_pkt", 64'(a_pkt), 64'h0);

    // 1: valid frame
    d0 = done_cnt;
    p = '{8'h1B, 8'h90, 8'h22, 8'hE0, 8'hFF};
    send_frame(0, p, 8'h00, 8'h00);
    @(negedge clk);
    check("t1_motor", 64'(a_motor), 64'h22901B);
    check("t1_signal", 64'(a_sig), 64'hE0);
    check("t1_kick", 64'(a_kick), 64'hFF);
    check("t1_crc_ok", 64'(a_succ), 64'h1);
    check("t1_crc", 64'(a_crc), 64'(crc_model(p)));
    check("t1_pkt", 64'(a_pkt), 64'h1);
    check("t1_done_pulses", 64'(done_cnt - d0), 64'h1);

    // 2: corrupted CRC keeps previous outputs
    d0 = done_cnt;
    p = '{8'h16, 8'h96, 8'h2D, 8'hE0, 8'h01};
    send_frame(0, p, 8'h01, 8'h00);
    @(negedge clk);
    check("t2_crc_ok", 64'(a_succ), 64'h0);
    check("t2_motor", 64'(a_motor), 64'h22901B);
    check("t2_kick", 64'(a_kick), 64'hFF);
    check("t2_pkt", 64'(a_pkt), 64'h1);
    check("t2_done_pulses", 64'(done_cnt - d0), 64'h1);

    // 3: garbage then FF FF FA resync
    send_byte(0, 8'h12);
    send_byte(0, 8'h34);
    send_byte(0, 8'hFF);
    p = '{8'h41, 8'h2E, 8'h58, 8'hE0, 8'h7F};
    send_frame(0, p, 8'h00, 8'h00);
    @(negedge clk);
    check("t3_motor", 64'(a_motor), 64'h582E41);
    check("t3_kick", 64'(a_kick), 64'h7F);
    check("t3_pkt", 64'(a_pkt), 64'h2);

    // 4: bad END, then timeout, then recovery
    e0 = err_cnt;
    p = '{8'h01, 8'h02, 8'h03, 8'hE0, 8'h11};
    send_frame(0, p, 8'h00, 8'h55);
    @(negedge clk);
    check("t4_end_err", 64'(err_cnt - e0), 64'h1);
    check("t4_end_motor", 64'(a_motor), 64'h582E41);
    e0 = err_cnt;
    send_byte(0, 8'hFF);
    send_byte(0, 8'hFA);
    send_byte(0, 8'h41);
    repeat (TMO + 5) @(posedge clk);
    @(negedge clk);
    check("t4_timeout_err", 64'(err_cnt - e0), 64'h1);
    p = '{8'hAA, 8'h55, 8'hFF, 8'hE0, 8'h02};
    send_frame(0, p, 8'h00, 8'h00);
    @(negedge clk);
    check("t4_recover_motor", 64'(a_motor), 64'hFF55AA);
    check("t4_recover_pkt", 64'(a_pkt), 64'h3);

    // 5: reset mid-frame
    send_byte(0, 8'hFF);
    send_byte(0, 8'hFA);
    send_byte(0, 8'h11);
    send_byte(0, 8'h22);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("t5_motor", 64'(a_motor), 64'h0);
    check("t5_kick", 64'(a_kick), 64'h0);
    check("t5_pkt", 64'(a_pkt), 64'h0);
    p = '{8'h0A, 8'h0B, 8'h0C, 8'hE0, 8'h33};
    send_frame(0, p, 8'h00, 8'h00);
    @(negedge clk);
    check("t5_after_motor", 64'(a_motor), 64'h0C0B0A);
    check("t5_after_pkt", 64'(a_pkt), 64'h1);

    // 6: five-motor instance and watchdog behaviour
    p = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hE0, 8'h00};
    send_frame(1, p, 8'h00, 8'h00);
    @(negedge clk);
    check("t6_motor", 64'(b_motor), 64'h0504030201);
    check("t6_signal", 64'(b_sig), 64'hE0);
    check("t6_crc_ok", 64'(b_succ), 64'h1);
    check("t6_pkt", 64'(b_pkt), 64'h1);
    repeat (WDG + 1) @(posedge clk);
    @(negedge clk);
`ifdef WATCHDOG_STOP_EN
    check("t6_wdog_motor", 64'(b_motor), 64'h0);
    check("t6_wdog_signal", 64'(b_sig), 64'h0);
`else
    check("t6_hold_motor", 64'(b_motor), 64'h0504030201);
    check("t6_hold_signal", 64'(b_sig), 64'hE0);
`endif
    check("t6_kick_held", 64'(b_kick), 64'h00);
    check("t6_pkt_held", 64'(b_pkt), 64'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_cmd_parser.md
Name: serial_cmd_parser

Overview:
Parametrised successor to the fixed 3-motor serial command decoder. Consumes UART-received bytes, frames packets of the form HDR0 HDR1 M[0..NUM_MOTORS-1] SIG KICK CRC_H CRC_L END, and checks a CRC-16/CCITT-FALSE over the payload. Motor, signal and kick registers update atomically only on a fully valid frame. Sits between the UART receiver and the motor/kicker drivers on the DE0-Nano motion board.

Parameters:
NUM_MOTORS, 3, number of motor command bytes per frame (1..8)
HDR0, 8'hFF, first header byte
HDR1, 8'hFA, second header byte
END_BYTE, 8'h00, frame terminator
TIMEOUT_CYC, 50000, max iCLK cycles between bytes inside a frame (1 ms at 50 MHz)
WDOG_CYC, 5000000, watchdog period in cycles (used only with the optional feature)

Ports:
iCLK  in  1  50 MHz clock
iRst_n  in  1  synchronous active-low reset
iRx_ready  in  1  byte-valid level from UART; a byte is accepted on its rising edge
iData  in  8  received byte, stable while iRx_ready is high
oCMD_Motor  out  8*NUM_MOTORS  motor commands, motor k at bits [8k+7:8k]
oSignal  out  8  EN/STOP byte
oKick  out  8  shoot byte
oRx_done  out  1  one-cycle pulse per completed frame (END position reached)
oCrcSuccess  out  1  result of the last completed frame, held until the next one
oCrc  out  16  CRC computed for the last completed frame
oFrameErr  out  1  one-cycle pulse on bad END byte or inter-byte timeout
oPktCount  out  16  count of accepted valid frames, wraps at 0xFFFF->0

Behaviour:
- Reset: iRst_n sampled low at an iCLK edge clears every output to 0, sets the state to IDLE, CRC to 16'hFFFF and edge register to 0. Reset mid-frame abandons the frame with no output update.
- Edge detect: rdy_q <= iRx_ready. Accept = iRx_ready & ~rdy_q. iData is sampled in the accept cycle. One byte per rising edge, however long the high time.
- States: IDLE, HDR, PAYLOAD, CRCH, CRCL, END.
  - IDLE: on byte==HDR0 -> HDR. Other bytes are ignored.
  - HDR: on byte==HDR1 -> PAYLOAD, idx=0, crc=FFFF. On byte==HDR0 stay in HDR (FF FF FA resync). Otherwise -> IDLE.
  - PAYLOAD: store byte in a shadow register and update crc. After NUM_MOTORS+2 bytes (motors, SIG, KICK) -> CRCH.
  - CRCH / CRCL: capture the received CRC high byte, then the low byte. CRCL -> END.
  - END: handled as below.
- CRC: poly 0x1021, init 0xFFFF, MSB-first, no reflection, no xorout. One byte per accept cycle, using a combinational 8-step update. Header, CRC and END bytes are excluded from the CRC.
- END byte == END_BYTE, accepted in cycle T. In cycle T+1:
  - oRx_done=1 for one cycle.
  - oCrc=computed CRC.
  - oCrcSuccess = (computed == received).
  - If the CRC matches: copy shadow registers to oCMD_Motor, oSignal and oKick, and increment oPktCount. On mismatch the outputs keep their previous values.
  - The state returns to IDLE.
- END byte != END_BYTE: oFrameErr pulses at T+1. No output, oCrc or oCrcSuccess change. State -> IDLE.
- Timeout: a counter clears on every accept and counts while state != IDLE. When it reaches TIMEOUT_CYC: oFrameErr pulses for one cycle, state -> IDLE, and outputs are unchanged.
- If a timeout and an accept fall in the same cycle, the accept wins and the counter clears.
- Payload bytes equal to HDR0 or HDR1 are treated as data (no mid-frame resync).

Optional Feature:
WATCHDOG_STOP_EN:
- Defined: a counter clears on each valid frame (the oCrcSuccess update with a match). When it reaches WDOG_CYC:
  - oCMD_Motor and oSignal are forced to 0 (motors disabled). oKick is unchanged.
  - The counter saturates.
  - The next valid frame restores normal updates.
- Undefined: outputs hold their last valid values indefinitely, and the watchdog logic is absent.

Test Plan:
1. After reset, send FF FA 1B 90 22 E0 FF + CRC from the bench CRC-16/CCITT-FALSE model + 00, with 3-cycle ready high/low -> Motor = 22_90_1B, oSignal=E0, oKick=FF, oRx_done pulses exactly 1 cycle, oCrcSuccess=1, oCrc=model value, oPktCount=1.
2. Repeat test 1 with payload 16 96 2D E0 01 and CRC_L XOR 0x01 -> oRx_done pulses, oCrcSuccess=0, outputs remain 22_90_1B/E0/FF, oPktCount=1.
3. Send garbage 12 34, then FF FF FA with valid payload 41 2E 58 E0 7F, CRC and 00 -> frame accepted, Motor=58_2E_41, oKick=7F.
4. Send a valid frame with END=55 -> oFrameErr pulse, no update. Then send FF FA 41 and stall TIMEOUT_CYC+5 cycles -> one oFrameErr pulse. Then send a valid frame -> accepted.
5. Assert iRst_n=0 for 1 cycle after the second payload byte -> all outputs 0. Next valid frame is decoded correctly.
6. NUM_MOTORS=5 instance, payload 01..05 E0 00 -> oCMD_Motor=05_04_03_02_01. With WATCHDOG_STOP_EN and WDOG_CYC=1000, stay idle 1001 cycles -> motors and signal become 0, oKick is held.
